// File: rtl/seq_restoring_divider_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared types for the iterative restoring divider.
//   div_state_t : controller states (IDLE -> CALC -> DONE -> IDLE)
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

endpackage : div_pkg

// File: rtl/seq_restoring_divider_sub.sv
// -----------------------------------------------------------------------------
// rca_subtractor
// N-bit ripple-borrow subtractor built from a chain of full-subtractor cells.
// Purely combinational: diff = a - b (mod 2^N), bout = 1 when a < b.
// Ports:
//   a    in  [N-1:0]  minuend
//   b    in  [N-1:0]  subtrahend
//   diff out [N-1:0]  difference
//   bout out          borrow out of the MSB cell
// -----------------------------------------------------------------------------
module rca_subtractor #(
    parameter int unsigned N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         bout
);

    logic [N:0] w_borrow;

    assign w_borrow[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_fs
        assign diff[i]       = a[i] ^ b[i] ^ w_borrow[i];
        assign w_borrow[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_borrow[i]);
    end

    assign bout = w_borrow[N];

endmodule : rca_subtractor

// File: rtl/seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider
// Iterative unsigned restoring divider: one quotient bit per clock using a
// shift-and-trial-subtract step. A start pulse in IDLE captures the operands;
// results appear WIDTH clocks later with a one-cycle done pulse. A zero
// divisor bypasses the iteration and reports quotient=all-ones,
// remainder=dividend, div_by_zero=1.
// Ports:
//   clk         in              rising-edge clock
//   rst_n       in              asynchronous active-low reset
//   start       in              request, sampled only in IDLE
//   dividend    in  [WIDTH-1:0] numerator, captured on accepted start
//   divisor     in  [WIDTH-1:0] denominator, captured on accepted start
//   busy        out             high while iterating
//   done        out             one-cycle pulse, results valid
//   quotient    out [WIDTH-1:0] registered quotient
//   remainder   out [WIDTH-1:0] registered remainder
//   div_by_zero out             registered divide-by-zero flag
// -----------------------------------------------------------------------------
module seq_restoring_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    import div_pkg::*;

    localparam int unsigned         CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]       LAST_CNT = CW'(WIDTH - 1);

    div_state_t       r_state;
    div_state_t       w_state_next;

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_dvs;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_trial;
    logic             w_borrow;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_last;
    logic             w_unused_trial_msb;

    // One iteration: shift the next dividend bit into the partial remainder
    // and try to subtract the divisor.
    assign w_shifted = {r_rem, r_q[WIDTH-1]};

    rca_subtractor #(
        .N (WIDTH + 1)
    ) u_sub (
        .a    (w_shifted),
        .b    ({1'b0, r_dvs}),
        .diff (w_trial),
        .bout (w_borrow)
    );

    // Partial remainder stays below the divisor, so a successful trial always
    // fits in WIDTH bits; its MSB is known zero and is not needed.
    assign w_unused_trial_msb = w_trial[WIDTH];

    assign w_rem_next = w_borrow ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_q_next   = {r_q[WIDTH-2:0], ~w_borrow};
    assign w_last     = (r_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem       <= '0;
            r_q         <= '0;
            r_dvs       <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            r_rem <= '0;
                            r_q   <= dividend;
                            r_dvs <= divisor;
                            r_cnt <= '0;
                        end else begin
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                            r_dbz       <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_quotient  <= w_q_next;
                        r_remainder <= w_rem_next;
                        r_dbz       <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule : seq_restoring_divider

// File: tb/tb_seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_restoring_divider
// Directed and exhaustive checks of seq_restoring_divider (WIDTH=4).
// Expected results are queued when an operation is issued and compared when
// done is observed.
// -----------------------------------------------------------------------------
module tb_seq_restoring_divider;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic [W-1:0] dd;
        logic [W-1:0] dv;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    exp_t sb[$];
    int   compared      = 0;
    int   mismatched    = 0;
    int   done_cnt      = 0;
    int   expected_done = 0;

    seq_restoring_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest issued request.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            exp_t e;
            done_cnt++;
            check("sb_depth", sb.size(), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("quotient %0d/%0d", e.dd, e.dv), quotient, e.q);
                check($sformatf("remainder %0d/%0d", e.dd, e.dv), remainder, e.r);
                check($sformatf("div_by_zero %0d/%0d", e.dd, e.dv), div_by_zero, e.dbz);
            end
        end
    end

    // Drive a request on a falling edge; returns just after the accepting edge.
    task automatic start_op(input logic [W-1:0] dd, input logic [W-1:0] dv);
        exp_t e;
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        e.dd  = dd;
        e.dv  = dv;
        e.q   = (dv == 0) ? {W{1'b1}} : W'(dd / dv);
        e.r   = (dv == 0) ? dd : W'(dd % dv);
        e.dbz = (dv == 0);
        sb.push_back(e);
        expected_done++;
        @(posedge clk);
    endtask

    // Issue one operation and wait (bounded) for its done pulse; optionally
    // disturb start and operands while the divider is iterating.
    task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv, input bit disturb);
        int n;
        bit seen;
        start_op(dd, dv);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            if (n == 0) start = 1'b0;
            if (disturb && n == 1) begin
                start    = 1'b1;
                dividend = 4'd1;
                divisor  = 4'd1;
            end
            if (disturb && n == 2) begin
                start    = 1'b0;
                dividend = '0;
                divisor  = '0;
            end
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (dv != 0) check("busy_in_calc", busy, 1);
                @(posedge clk);
                n++;
            end
        end
        check("done_seen", seen, 1);
        if (dv != 0) check($sformatf("latency %0d/%0d", dd, dv), n, W);
        if (seen) begin
            check("busy_at_done", busy, 0);
            @(posedge clk);
            #1;
            check("done_one_cycle", done, 0);
        end
    endtask

    initial begin
        int d0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'd13, 4'd4, 1'b0);
        run_op(4'd15, 4'd1, 1'b0);
        run_op(4'd3,  4'd7, 1'b0);
        run_op(4'd0,  4'd5, 1'b0);
        run_op(4'd9,  4'd0, 1'b0);
        run_op(4'd8,  4'd2, 1'b0);

        // Start/operand changes during CALC must not disturb the result.
        d0 = done_cnt;
        run_op(4'd14, 4'd3, 1'b1);
        check("single_done", done_cnt - d0, 1);
        repeat (3) @(negedge clk);
        check("hold_quotient", quotient, 4);
        check("hold_remainder", remainder, 2);

        // Reset in the middle of an operation aborts it without a done.
        start_op(4'd12, 4'd5);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_dbz", div_by_zero, 0);
        void'(sb.pop_back());
        expected_done--;
        d0 = done_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("no_done_after_abort", done_cnt, d0);
        check("idle_after_abort", busy, 0);
        run_op(4'd12, 4'd5, 1'b0);

        // Exhaustive sweep at the minimum issue interval.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(W'(a), W'(b), 1'b0);
            end
        end

        repeat (4) @(negedge clk);
        check("done_count", done_cnt, expected_done);
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_seq_restoring_divider
